// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Holds the FSM encoding, the largest displayable BCD value and a width helper.
package display_pkg;

  typedef enum logic {
    TROCA = 1'b0,
    EXIBE = 1'b1
  } estado_t;

  localparam int BCD_MAX = 9;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prescaler_scan.sv
// Per-digit dwell counter: counts while enabled and flags the last cycle of the dwell.
// Latency: fim is decoded from the registered count; clear takes effect on the next edge.
// Backpressure: none, free-running whenever conta is high.
module prescaler_scan
  import display_pkg::*;
#(
  parameter int DIV_SCAN = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim
);

  localparam int PW = clog2(DIV_SCAN);

  logic [PW-1:0] pre;

  assign fim = (pre == PW'(DIV_SCAN - 1));

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      pre <= '0;
    end else if (conta) begin
      pre <= fim ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/controlador_display_mux.sv
// Scan controller sharing one BCD decoder across NUM_DIGITOS digits, with a blank gap between digits.
// Latency: loads land on the next frame boundary; outputs decode registered state only.
// Backpressure: none; a repeated load overwrites the pending value. Option: SUPRESSAO_ZEROS_EN.
module controlador_display_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITOS = 4,
  parameter int DIV_SCAN    = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     carrega,
  input  logic [4*NUM_DIGITOS-1:0] dados,
  output logic                     pendente,
  output logic [3:0]               bcd_out,
  output logic                     en_out,
  output logic [NUM_DIGITOS-1:0]   digito_sel
);

  localparam int IW = clog2(NUM_DIGITOS);
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_DIGITOS - 1);

  estado_t                  estado, estado_prox;
  logic [IW-1:0]            idx;
  logic [4*NUM_DIGITOS-1:0] exib, buf_dados;
  logic                     pend;
  logic                     fim;
  logic                     fronteira;
  logic [3:0]               digito;
  logic                     apagado;
`ifdef SUPRESSAO_ZEROS_EN
  logic                     zeros;
`endif

  prescaler_scan #(.DIV_SCAN(DIV_SCAN)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .limpa (estado == TROCA),
    .conta (estado == EXIBE),
    .fim   (fim)
  );

  // Leaving the gap after the last digit starts a new frame at digit 0.
  assign fronteira = (estado == TROCA) && (idx == ULTIMO);

  always_comb begin
    estado_prox = estado;
    case (estado)
      TROCA:   estado_prox = EXIBE;
      EXIBE:   if (fim) estado_prox = TROCA;
      default: estado_prox = TROCA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= TROCA;
      idx       <= ULTIMO;
      exib      <= '0;
      buf_dados <= '0;
      pend      <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado == TROCA) begin
        idx <= (idx == ULTIMO) ? '0 : idx + IW'(1);
      end
      if (fronteira) begin
        if (carrega) begin
          exib <= dados;
        end else if (pend) begin
          exib <= buf_dados;
        end
        pend <= 1'b0;
      end else if (carrega) begin
        buf_dados <= dados;
        pend      <= 1'b1;
      end
    end
  end

  // Scan from the most significant digit down so leading zeros accumulate.
  always_comb begin
    digito  = '0;
    apagado = 1'b0;
`ifdef SUPRESSAO_ZEROS_EN
    zeros   = 1'b1;
`endif
    for (int j = NUM_DIGITOS - 1; j >= 0; j--) begin
`ifdef SUPRESSAO_ZEROS_EN
      zeros = zeros && (exib[4*j +: 4] == 4'd0);
`endif
      if (idx == IW'(j)) begin
        digito = exib[4*j +: 4];
`ifdef SUPRESSAO_ZEROS_EN
        apagado = zeros && (j != 0);
`endif
      end
    end
  end

  assign pendente   = pend;
  assign bcd_out    = (estado == EXIBE) ? digito : 4'd0;
  assign en_out     = (estado == EXIBE) && (digito <= 4'(BCD_MAX)) && !apagado;
  assign digito_sel = (estado == EXIBE) ? ({{(NUM_DIGITOS-1){1'b0}}, 1'b1} << idx)
                                        : '0;

endmodule

// File: tb/tb_controlador_display_mux.sv
// Directed plus random stimulus against a frame-timing reference model of the scan controller.
module tb_controlador_display_mux;

  localparam int N     = 4;
  localparam int D     = 3;
  localparam int FRAME = N * (D + 1);

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           carrega = 1'b0;
  logic [4*N-1:0] dados = '0;
  logic           pendente;
  logic [3:0]     bcd_out;
  logic           en_out;
  logic [N-1:0]   digito_sel;

  int total = 0;
  int bad   = 0;

  // Reference model: t counts edges since reset release (-1 = held in reset).
  int             t = -1;
  logic [4*N-1:0] exib_m = '0;
  logic [4*N-1:0] buf_m  = '0;
  bit             pend_m = 1'b0;

  controlador_display_mux #(.NUM_DIGITOS(N), .DIV_SCAN(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .carrega    (carrega),
    .dados      (dados),
    .pendente   (pendente),
    .bcd_out    (bcd_out),
    .en_out     (en_out),
    .digito_sel (digito_sel)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit c, input logic [4*N-1:0] d);
    int dg;
    logic [3:0] nib;
    logic [3:0] e_bcd;
    logic       e_en;
    logic [N-1:0] e_sel;
    @(negedge clock);
    reset   = r;
    carrega = c;
    dados   = d;
    @(posedge clock);
    if (r) begin
      t = -1; exib_m = '0; buf_m = '0; pend_m = 1'b0;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        if (c) exib_m = d;
        else if (pend_m) exib_m = buf_m;
        pend_m = 1'b0;
      end else if (c) begin
        buf_m  = d;
        pend_m = 1'b1;
      end
    end
    e_bcd = '0; e_en = 1'b0; e_sel = '0;
    if (t >= 0 && (t % (D + 1)) != D) begin
      dg    = (t / (D + 1)) % N;
      nib   = 4'((exib_m >> (4 * dg)) & 16'hF);
      e_bcd = nib;
      e_sel = N'(1) << dg;
      e_en  = (nib <= 9);
`ifdef SUPRESSAO_ZEROS_EN
      if (dg > 0 && (exib_m >> (4 * dg)) == 0) e_en = 1'b0;
`endif
    end
    #1;
    chk("bcd_out",    32'(bcd_out),    32'(e_bcd));
    chk("en_out",     32'(en_out),     32'(e_en));
    chk("digito_sel", 32'(digito_sel), 32'(e_sel));
    chk("pendente",   32'(pendente),   32'(pend_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic to_boundary_load(input logic [4*N-1:0] d);
    while (((t + 1) % FRAME) != 0) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, d);
  endtask

  initial begin
    // Reset held, then first edge after release enters digit 0.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    idle(18);

    // Mid-frame load lands at the next boundary.
    step(1'b0, 1'b1, 16'h4321);
    idle(2 * FRAME);
    idle(5);
    step(1'b0, 1'b1, 16'h9876);
    idle(FRAME + 4);

    // Latest of two pending loads wins; boundary load is immediate.
    idle(3);
    step(1'b0, 1'b1, 16'h1111);
    idle(2);
    step(1'b0, 1'b1, 16'h2222);
    idle(FRAME);
    to_boundary_load(16'h5555);
    idle(FRAME);

    // Invalid digit on position 2, then leading-zero pattern.
    to_boundary_load(16'h1A23);
    idle(FRAME);
    to_boundary_load(16'h0070);
    idle(FRAME + 2);

    // Reset mid-frame with a load pending.
    step(1'b0, 1'b1, 16'h3141);
    step(1'b1, 1'b0, '0);
    idle(FRAME);

    // Random loads, invalid nibbles and occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit r, c;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) step(r, c, 16'($urandom_range(0, 255)));
      else step(r, c, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
